counter_run_ctrl: RTL and testbench
===================================

// Module: counter_run_ctrl
// PURPOSE
//  Run controller and sequencer for the FSM-based up counter.
//  - Start/pause/abort control; latched terminal count; one-shot or auto-reload mode.
//  - Drives the count value and a terminal-count "done" pulse to downstream FSMs.
//  - Sits between the control/test logic and any block that consumes a bounded count.
// PARAMETERS
//  WIDTH  3  count and limit width in bits; count range 0..2^WIDTH-1
// PORTS
//  clk          in   1      system clock, all logic on posedge
//  reset_n      in   1      asynchronous, active-low reset
//  start        in   1      IDLE/DONE: load and run; PAUSE: resume; RUN: ignored
//  stop         in   1      RUN: pause (count holds); other states: ignored
//  abort        in   1      any state: return to IDLE, count cleared
//  tick         in   1      count-enable qualifier, used in RUN only
//  limit_in     in   WIDTH  terminal count, sampled on a loading start
//  reload_in    in   1      1 = auto-reload, 0 = one-shot; sampled with limit_in
//  count        out  WIDTH  current count value (registered)
//  busy         out  1      1 in RUN or PAUSE
//  done         out  1      one-cycle pulse on terminal count
//  state        out  2      IDLE=0, RUN=1, PAUSE=2, DONE=3
// BEHAVIOUR
//  Clocking and reset
//  - Single clock. All outputs are registered.
//  - Async reset (reset_n=0): state=IDLE, count=0, limit=0, reload=0, done=0, busy=0.
//  Input priority (same cycle): abort > stop > start > tick.
//  IDLE
//  - count=0.
//  - start: limit<=limit_in, reload<=reload_in, count<=0, go RUN.
//  RUN, with tick=1:
//  - count!=limit: count<=count+1.
//  - count==limit, reload=1: count<=0, done=1 for one cycle, stay RUN.
//  - count==limit, reload=0: count holds at limit, done=1 for one cycle, go DONE.
//  RUN, other cases
//  - tick=0: count holds.
//  - stop: go PAUSE; that cycle's tick is ignored.
//  PAUSE
//  - count and limit hold.
//  - start: go RUN. No reload; limit_in is not sampled.
//  DONE
//  - count holds at limit.
//  - start: reload from limit_in/reload_in, count<=0, go RUN.
//  Timing and limits
//  - Latency: a start with limit=L and tick held at 1 gives done L+1 cycles after the first RUN cycle.
//  - limit=0: done on the first tick in RUN.
//  - Wrap: count never exceeds limit. For limit=2^WIDTH-1, the increment path never overflows; the terminal compare takes over.
//  - done is asserted only on the clock edge that processes a terminal tick. It is never asserted in IDLE, PAUSE or DONE.
//  - abort in any state: next cycle state=IDLE, count=0, done=0.
//    abort in the terminal cycle suppresses done.
//  - Reset mid-run: outputs go to reset values immediately, without waiting for clk.
//  - Unused state encodings recover to IDLE on the next clock.
// TESTING
//  T1 reset: reset_n=0 mid-RUN at count=5 -> count=0, state=0, busy=0, done=0 immediately.
//  T2 one-shot: limit_in=5, reload_in=0, start, tick=1 -> count 0,1,2,3,4,5; done pulses once; state=3; count holds at 5.
//  T3 auto-reload: limit_in=7, reload_in=1, tick=1 for 20 cycles -> count 0..7,0..7,0..3; done pulses at each 7->0.
//  T4 pause/resume: stop at count=3 with tick=1 -> count holds at 3 for 4 cycles.
//     Then start with limit_in=1 -> resumes 4,5,...; original limit kept.
//  T5 priority: abort, stop and start together in RUN -> IDLE, count=0.
//     stop and tick together -> PAUSE with count unchanged.
//  T6 edge cases: limit_in=0 -> done on first tick.
//     tick toggling 1,0,1,0 -> count advances only on tick=1.
//     start in RUN -> ignored.

Source files
------------

// File: rtl/counter_run_ctrl.sv
// rtl/counter_run_ctrl.sv - run controller for a bounded up counter
// Start/pause/abort sequencing with latched limit, one-shot or auto-reload.
module counter_run_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             abort,
    input  logic             tick,
    input  logic [WIDTH-1:0] limit_in,
    input  logic             reload_in,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             reload_q, reload_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             at_limit;

    // The increment is only taken below the limit, so it can never wrap past 2^WIDTH-1.
    assign at_limit = (count_q == limit_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            limit_q  <= '0;
            reload_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            limit_q  <= limit_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        limit_d  = limit_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    count_d = '0;
                    if (start) begin
                        limit_d  = limit_in;
                        reload_d = reload_in;
                        state_d  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // stop wins over the same-cycle tick; start is ignored here.
                    if (stop) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        if (!at_limit) begin
                            count_d = count_q + WIDTH'(1);
                        end else begin
                            done_d = 1'b1;
                            if (reload_q) begin
                                count_d = '0;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        limit_d  = limit_in;
                        reload_d = reload_in;
                        count_d  = '0;
                        state_d  = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign state = state_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// tb/tb_counter_run_ctrl.sv - scoreboard bench for counter_run_ctrl
module tb_counter_run_ctrl;

    localparam int W = 3;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0, stop = 1'b0, abort = 1'b0, tick = 1'b0, reload_in = 1'b0;
    logic [W-1:0] limit_in = '0;
    logic [W-1:0] count;
    logic         busy, done;
    logic [1:0]   state;

    typedef struct {
        int         id;
        logic [W-1:0] cnt;
        logic [1:0] st;
        logic       dn;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   vec = 0;

    counter_run_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .abort(abort),
        .tick(tick), .limit_in(limit_in), .reload_in(reload_in),
        .count(count), .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [W-1:0] c, input logic [1:0] s, input logic d);
        exp_t e;
        e.id = vec; e.cnt = c; e.st = s; e.dn = d;
        q.push_back(e);
        vec++;
    endtask

    task automatic cyc(input logic st_i, input logic sp_i, input logic ab_i, input logic tk_i,
                       input logic [W-1:0] lim_i, input logic rl_i,
                       input logic [W-1:0] ec, input logic [1:0] es, input logic ed);
        @(negedge clk);
        start = st_i; stop = sp_i; abort = ab_i; tick = tk_i;
        limit_in = lim_i; reload_in = rl_i;
        @(posedge clk);
        #1;
        push(ec, es, ed);
    endtask

    // Monitor: one registered output set per cycle, compared against the scoreboard head.
    initial begin
        exp_t e;
        logic eb;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e  = q.pop_front();
                eb = (e.st == RUN) || (e.st == PAUSE);
                checks++;
                if (count !== e.cnt) begin
                    failures++;
                    $display("FAIL v%0d count got=%0d exp=%0d", e.id, count, e.cnt);
                end
                checks++;
                if (state !== e.st) begin
                    failures++;
                    $display("FAIL v%0d state got=%0d exp=%0d", e.id, state, e.st);
                end
                checks++;
                if (busy !== eb) begin
                    failures++;
                    $display("FAIL v%0d busy got=%0b exp=%0b", e.id, busy, eb);
                end
                checks++;
                if (done !== e.dn) begin
                    failures++;
                    $display("FAIL v%0d done got=%0b exp=%0b", e.id, done, e.dn);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] c;
        logic         d;
        int           budget;

        // Reset state while reset_n is still low.
        #1 push(0, IDLE, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;

        // T2 one-shot, limit 5
        cyc(1, 0, 0, 0, 5, 0, 0, RUN, 0);
        for (int i = 1; i <= 5; i++) cyc(0, 0, 0, 1, 0, 0, W'(i), RUN, 0);
        cyc(0, 0, 0, 1, 0, 0, 5, DONE, 1);
        cyc(0, 0, 0, 1, 0, 0, 5, DONE, 0);
        cyc(0, 1, 0, 1, 0, 0, 5, DONE, 0);

        // T3 auto-reload, limit 7 (max value), 20 ticks
        cyc(1, 0, 0, 1, 7, 1, 0, RUN, 0);
        c = 0;
        for (int i = 0; i < 20; i++) begin
            d = (c == 7);
            c = d ? 3'd0 : c + 3'd1;
            cyc(0, 0, 0, 1, 0, 0, c, RUN, d);
        end

        // T4 pause/resume keeps the original limit
        cyc(0, 0, 1, 0, 0, 0, 0, IDLE, 0);
        cyc(1, 0, 0, 0, 6, 0, 0, RUN, 0);
        for (int i = 1; i <= 3; i++) cyc(0, 0, 0, 1, 0, 0, W'(i), RUN, 0);
        cyc(0, 1, 0, 1, 0, 0, 3, PAUSE, 0);
        for (int i = 0; i < 4; i++) cyc(0, i[0], 0, 1, 0, 0, 3, PAUSE, 0);
        cyc(1, 0, 0, 1, 1, 0, 3, RUN, 0);
        for (int i = 4; i <= 6; i++) cyc(0, 0, 0, 1, 0, 0, W'(i), RUN, 0);
        cyc(0, 0, 0, 1, 0, 0, 6, DONE, 1);

        // T5 priority
        cyc(1, 0, 0, 0, 7, 0, 0, RUN, 0);
        cyc(0, 0, 0, 1, 0, 0, 1, RUN, 0);
        cyc(0, 0, 0, 1, 0, 0, 2, RUN, 0);
        cyc(1, 1, 1, 1, 0, 0, 0, IDLE, 0);
        cyc(1, 0, 0, 0, 7, 0, 0, RUN, 0);
        cyc(0, 0, 0, 1, 0, 0, 1, RUN, 0);
        cyc(0, 1, 0, 1, 0, 0, 1, PAUSE, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, IDLE, 0);
        // abort on the terminal tick suppresses done
        cyc(1, 0, 0, 0, 2, 0, 0, RUN, 0);
        cyc(0, 0, 0, 1, 0, 0, 1, RUN, 0);
        cyc(0, 0, 0, 1, 0, 0, 2, RUN, 0);
        cyc(0, 0, 1, 1, 0, 0, 0, IDLE, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, IDLE, 0);

        // T6 limit 0, tick toggling, start ignored in RUN
        cyc(1, 0, 0, 0, 0, 0, 0, RUN, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, DONE, 1);
        cyc(1, 0, 0, 0, 3, 1, 0, RUN, 0);
        cyc(0, 0, 0, 1, 0, 0, 1, RUN, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, RUN, 0);
        cyc(0, 0, 0, 1, 0, 0, 2, RUN, 0);
        cyc(0, 0, 0, 0, 0, 0, 2, RUN, 0);
        cyc(1, 0, 0, 0, 0, 0, 2, RUN, 0);
        cyc(0, 0, 0, 1, 0, 0, 3, RUN, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, RUN, 1);

        // T1 asynchronous reset mid-run at count 5
        cyc(0, 0, 1, 0, 0, 0, 0, IDLE, 0);
        cyc(1, 0, 0, 0, 7, 0, 0, RUN, 0);
        for (int i = 1; i <= 5; i++) cyc(0, 0, 0, 1, 0, 0, W'(i), RUN, 0);
        @(negedge clk);
        start = 0; stop = 0; abort = 0; tick = 1;
        @(posedge clk);
        #2 reset_n = 1'b0;
        push(0, IDLE, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        cyc(0, 0, 0, 1, 0, 0, 0, IDLE, 0);

        budget = 0;
        while (q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
